// File: rtl/kf_sub_pkg.sv
// Shared constants and types for the Kalman subtractor scheduler.
package kf_sub_pkg;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int SUB_LAT = 12;
    localparam int TAG_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // One in-flight operation: who asked for it, and whether the slot is live.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    // Turn a returning tag into the one-hot response strobe.
    function automatic logic [NUM_REQ-1:0] tag_to_onehot(input logic [TAG_W-1:0] tag);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            oh[i] = (tag == TAG_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/kf_sub_scheduler_if.sv
// Requester-side and subtractor-side signals of the shared subtractor scheduler.
interface kf_sub_scheduler_if;
    import kf_sub_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [DATA_W-1:0]         sub_dataa;
    logic [DATA_W-1:0]         sub_datab;
    logic                      sub_valid;
    logic [DATA_W-1:0]         sub_result;
    logic                      busy;

    // The scheduler itself.
    modport slave (
        input  req_valid, req_a, req_b, sub_result,
        output req_ready, rsp_valid, rsp_data, sub_dataa, sub_datab, sub_valid, busy
    );

    // The stage controllers plus subtractor, seen from outside the scheduler.
    modport master (
        output req_valid, req_a, req_b, sub_result,
        input  req_ready, rsp_valid, rsp_data, sub_dataa, sub_datab, sub_valid, busy
    );

endinterface

// File: rtl/kf_rr_arbiter.sv
// Round-robin arbiter: searches upward from the last winner + 1.
module kf_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       upd_en,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   ptr_r;
    logic [NUM_REQ-1:0] gnt_s;
    logic [IDX_W-1:0]   idx_s;

    // Pick the first requester after the pointer, wrapping at NUM_REQ.
    always_comb begin
        logic found;
        int   cand;
        gnt_s = '0;
        idx_s = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(ptr_r) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!found && req[IDX_W'(cand)]) begin
                found                = 1'b1;
                gnt_s[IDX_W'(cand)]  = 1'b1;
                idx_s                = IDX_W'(cand);
            end else begin
                found = found;
            end
        end
    end

    // Pointer remembers the last winner; reset value makes requester 0 first.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            ptr_r <= IDX_W'(NUM_REQ - 1);
        end else if (upd_en) begin
            ptr_r <= idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt     = gnt_s;
    assign gnt_idx = idx_s;

endmodule

// File: rtl/kf_sub_scheduler.sv
// Shares one pipelined FP subtractor among NUM_REQ requesters, one op per cycle,
// and routes each result back to its requester via a tag pipeline.
module kf_sub_scheduler
    import kf_sub_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    kf_sub_scheduler_if.slave bus
);

    logic [NUM_REQ-1:0]     req_s;
    logic [NUM_REQ-1:0]     gnt_s;
    logic [TAG_W-1:0]       gnt_idx_s;
    logic                   hs_s;
    logic [DATA_W-1:0]      sel_a_s;
    logic [DATA_W-1:0]      sel_b_s;
    logic                   pipe_any_s;
    logic [NUM_REQ-1:0]     rsp_valid_n_s;
    logic [DATA_W-1:0]      rsp_data_n_s;

    // issue_r rides alongside sub_valid; pipe_r[SUB_LAT] lines up with sub_result.
    tag_entry_t                 issue_r;
    tag_entry_t [SUB_LAT:1]     pipe_r;
    logic [DATA_W-1:0]          dataa_r;
    logic [DATA_W-1:0]          datab_r;
    logic [NUM_REQ-1:0]         rsp_valid_r;
    logic [DATA_W-1:0]          rsp_data_r;
    logic                       busy_r;

    // No grants at all while held in reset.
    assign req_s = bus.req_valid & {NUM_REQ{resetn}};

    kf_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clock   (clock),
        .resetn  (resetn),
        .req     (req_s),
        .upd_en  (hs_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign hs_s          = |gnt_s;
    assign bus.req_ready = gnt_s;

    // Operand mux: AND-OR over the one-hot grant.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i]) begin
                sel_a_s = sel_a_s | bus.req_a[i*DATA_W +: DATA_W];
                sel_b_s = sel_b_s | bus.req_b[i*DATA_W +: DATA_W];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    // Response decode and in-flight summary for busy.
    always_comb begin
        pipe_any_s = 1'b0;
        for (int k = 1; k <= SUB_LAT; k++) begin
            pipe_any_s = pipe_any_s | pipe_r[k].valid;
        end
        if (pipe_r[SUB_LAT].valid) begin
            rsp_valid_n_s = tag_to_onehot(pipe_r[SUB_LAT].tag);
            rsp_data_n_s  = bus.sub_result;
        end else begin
            rsp_valid_n_s = '0;
            rsp_data_n_s  = rsp_data_r;
        end
    end

    // Issue registers, tag shift register and registered response outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            issue_r     <= '0;
            pipe_r      <= '0;
            dataa_r     <= '0;
            datab_r     <= '0;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            issue_r.valid <= hs_s;
            issue_r.tag   <= gnt_idx_s;
            if (hs_s) begin
                dataa_r <= sel_a_s;
                datab_r <= sel_b_s;
            end else begin
                dataa_r <= dataa_r;
                datab_r <= datab_r;
            end
            pipe_r[1] <= issue_r;
            for (int k = 2; k <= SUB_LAT; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
            rsp_valid_r <= rsp_valid_n_s;
            rsp_data_r  <= rsp_data_n_s;
            // Stays high through the response cycle, since pipe_r[SUB_LAT] feeds it.
            busy_r      <= hs_s | issue_r.valid | pipe_any_s;
        end
    end

    assign bus.sub_valid = issue_r.valid;
    assign bus.sub_dataa = dataa_r;
    assign bus.sub_datab = datab_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.busy      = busy_r;

endmodule
